// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and encodings for the RV32I multicycle control unit
// Purpose: FSM state type, RV32I opcode classes, decoded-field encodings and the
//          decoded-field bundle passed from cu_decode to the FSM.
// Ports:   none (package).
// Config:  CU_MULDIV_EN is consumed by multicycle_controlunit, not by this package.
package cu_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      MULDIV = 3'd5,
      TRAP   = 3'd6
   } state_e;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [3:0] ALUOP_ZERO = 4'b0000;
   localparam logic [3:0] ALUOP_U    = 4'b0111;

   localparam logic [1:0] RU_ALU = 2'b00;
   localparam logic [1:0] RU_MEM = 2'b01;
   localparam logic [1:0] RU_PC4 = 2'b10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   // BrOp: 00000 no branch, 01000 unconditional jump, 10fff conditional on Funct3.
   localparam logic [4:0] BR_NONE = 5'b00000;
   localparam logic [4:0] BR_JUMP = 5'b01000;
   localparam logic [1:0] BR_COND = 2'b10;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [2:0] imm_src;
      logic       alu_a_src;
      logic       alu_b_src;
      logic [4:0] br_op;
      logic [2:0] dm_ctrl;
      logic [1:0] ru_src;
      logic       is_branch;
      logic       is_jump;
      logic       is_load;
      logic       is_store;
      logic       is_muldiv;
   } dec_t;

   function automatic logic is_legal_op(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational RV32I field decoder fed by the decode register
// Purpose: turns the latched OpCode/Funct3/Funct7 into ALU, immediate, branch,
//          data-memory and write-back selects plus instruction-class flags.
// Ports:   op     in  7  latched opcode
//          funct3 in  3  latched Funct3
//          funct7 in  7  latched Funct7
//          dec    out    decoded field bundle (cu_pkg::dec_t); all zero for unknown opcodes
module cu_decode
   import cu_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output dec_t       dec
);

   always_comb begin
      dec = '0;
      case (op)
         OP_R: begin
            dec.alu_op    = {funct7[5], funct3};
            dec.ru_src    = RU_ALU;
            dec.is_muldiv = (funct7 == F7_MULDIV);
         end
         OP_I: begin
            dec.imm_src   = IMM_I;
            dec.alu_b_src = 1'b1;
            // Only the shifts use instr[30] as an opcode bit; elsewhere it is immediate data.
            dec.alu_op    = (funct3 == 3'b001 || funct3 == 3'b101) ?
                            {funct7[5], funct3} : {1'b0, funct3};
         end
         OP_LOAD: begin
            dec.imm_src   = IMM_I;
            dec.alu_b_src = 1'b1;
            dec.dm_ctrl   = funct3;
            dec.ru_src    = RU_MEM;
            dec.is_load   = 1'b1;
         end
         OP_STORE: begin
            dec.imm_src   = IMM_S;
            dec.alu_b_src = 1'b1;
            dec.dm_ctrl   = funct3;
            dec.is_store  = 1'b1;
         end
         OP_BR: begin
            dec.imm_src   = IMM_B;
            dec.alu_a_src = 1'b1;
            dec.alu_b_src = 1'b1;
            dec.br_op     = {BR_COND, funct3};
            dec.is_branch = 1'b1;
         end
         OP_JAL: begin
            dec.imm_src   = IMM_J;
            dec.alu_a_src = 1'b1;
            dec.alu_b_src = 1'b1;
            dec.br_op     = BR_JUMP;
            dec.ru_src    = RU_PC4;
            dec.is_jump   = 1'b1;
         end
         OP_JALR: begin
            dec.imm_src   = IMM_I;
            dec.alu_b_src = 1'b1;
            dec.br_op     = BR_JUMP;
            dec.ru_src    = RU_PC4;
            dec.is_jump   = 1'b1;
         end
         OP_LUI: begin
            dec.imm_src   = IMM_U;
            dec.alu_b_src = 1'b1;
            dec.alu_op    = ALUOP_U;
         end
         OP_AUIPC: begin
            dec.imm_src   = IMM_U;
            dec.alu_a_src = 1'b1;
            dec.alu_b_src = 1'b1;
            dec.alu_op    = ALUOP_U;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controlunit.sv
// rtl/multicycle_controlunit.sv - RV32I multicycle control unit (FETCH/DECODE/EXEC/MEM/WB)
// Purpose: sequences one shared datapath through FETCH, DECODE, EXEC, MEM and WB with
//          req/ack memories, a per-request wait counter, a sticky trap state and a
//          retired-instruction counter.
// Config:  CU_MULDIV_EN adds the MULDIV state and the mdu_start/mdu_done ports; without
//          it an R-type with Funct7=0000001 traps.
// Params:  RET_W        width of the retired counter
//          MEM_TIMEOUT  consecutive unacked req cycles before trapping; 0 = never
// Ports:   clk, rst_n (async active-low)
//          OpCode/Funct3/Funct7 in   instruction register fields
//          imem_req/imem_ack, dmem_req/dmem_ack   memory handshakes
//          br_taken in   branch unit verdict for the instruction in EXEC
//          IRWr, PCWr, RUWr out   single-cycle write strobes
//          ALUOp, ImmSrc, ALUASrc, ALUBSrc, BrOp, DMWr, DMCtrl, RUDataWrSrc out   datapath controls
//          trap, retired out   status
//          mdu_start out / mdu_done in   multiply/divide handshake (CU_MULDIV_EN only)
module multicycle_controlunit
   import cu_pkg::*;
#(
   parameter int RET_W       = 32,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       OpCode,
   input  logic [2:0]       Funct3,
   input  logic [6:0]       Funct7,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             br_taken,
   output logic             IRWr,
   output logic             PCWr,
   output logic             RUWr,
   output logic [3:0]       ALUOp,
   output logic [2:0]       ImmSrc,
   output logic             ALUASrc,
   output logic             ALUBSrc,
   output logic             DMWr,
   output logic [2:0]       DMCtrl,
   output logic [4:0]       BrOp,
   output logic [1:0]       RUDataWrSrc,
   output logic             trap,
   output logic [RET_W-1:0] retired
`ifdef CU_MULDIV_EN
   ,
   output logic             mdu_start,
   input  logic             mdu_done
`endif
);

   localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_e           state_q, state_d;
   logic [6:0]       op_q, f7_q;
   logic [2:0]       f3_q;
   logic [WC_W-1:0]  wcnt_q, wcnt_d;
   logic [RET_W-1:0] ret_q;
   logic             dec_ld, retire, tmo_hit;
   dec_t             dec;

   cu_decode u_decode (
      .op     (op_q),
      .funct3 (f3_q),
      .funct7 (f7_q),
      .dec    (dec)
   );

`ifdef CU_MULDIV_EN
`else
   logic unused_muldiv;
   assign unused_muldiv = dec.is_muldiv;
`endif

   // Fires on the last allowed unacked cycle; an ack in that same cycle still wins.
   assign tmo_hit = (MEM_TIMEOUT > 0) && (wcnt_q == WC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         op_q    <= '0;
         f3_q    <= '0;
         f7_q    <= '0;
         wcnt_q  <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (dec_ld) begin
            op_q <= OpCode;
            f3_q <= Funct3;
            f7_q <= Funct7;
         end
         if (retire) ret_q <= ret_q + RET_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      wcnt_d   = '0;
      dec_ld   = 1'b0;
      retire   = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      IRWr     = 1'b0;
      PCWr     = 1'b0;
      RUWr     = 1'b0;
      DMWr     = 1'b0;
      ALUASrc  = 1'b0;
      ALUBSrc  = 1'b0;
      BrOp     = BR_NONE;
`ifdef CU_MULDIV_EN
      mdu_start = 1'b0;
`endif
      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               IRWr    = 1'b1;
               state_d = DECODE;
            end else if (tmo_hit) begin
               state_d = TRAP;
            end else begin
               wcnt_d = wcnt_q + WC_W'(1);
            end
         end
         DECODE: begin
            // Legality is judged on the live IR; the fields are latched on this edge.
            dec_ld = 1'b1;
            if (!is_legal_op(OpCode)) state_d = TRAP;
`ifdef CU_MULDIV_EN
            else state_d = EXEC;
`else
            else if (OpCode == OP_R && Funct7 == F7_MULDIV) state_d = TRAP;
            else state_d = EXEC;
`endif
         end
         EXEC: begin
            ALUASrc = dec.alu_a_src;
            ALUBSrc = dec.alu_b_src;
            BrOp    = dec.br_op;
            if (dec.is_branch) begin
               PCWr    = br_taken;
               retire  = 1'b1;
               state_d = FETCH;
            end else if (dec.is_jump) begin
               PCWr    = 1'b1;
               state_d = WB;
            end else if (dec.is_load || dec.is_store) begin
               state_d = MEM;
`ifdef CU_MULDIV_EN
            end else if (dec.is_muldiv) begin
               // Issued on the EXEC->MULDIV edge so the MDU starts as the FSM arrives.
               mdu_start = 1'b1;
               state_d   = MULDIV;
`endif
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            DMWr     = dec.is_store;
            if (dmem_ack) begin
               if (dec.is_store) begin
                  PCWr    = 1'b1;
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end else if (tmo_hit) begin
               state_d = TRAP;
            end else begin
               wcnt_d = wcnt_q + WC_W'(1);
            end
         end
         WB: begin
            RUWr    = 1'b1;
            PCWr    = !dec.is_jump;
            retire  = 1'b1;
            state_d = FETCH;
         end
         MULDIV: begin
`ifdef CU_MULDIV_EN
            if (mdu_done) state_d = WB;
`else
            state_d = TRAP;
`endif
         end
         TRAP:    state_d = TRAP;
         default: state_d = TRAP;
      endcase
   end

   assign ALUOp       = dec.alu_op;
   assign ImmSrc      = dec.imm_src;
   assign DMCtrl      = dec.dm_ctrl;
   assign RUDataWrSrc = dec.ru_src;
   assign trap        = (state_q == TRAP);
   assign retired     = ret_q;

endmodule

// File: tb/tb_multicycle_controlunit.sv
// tb/tb_multicycle_controlunit.sv - directed self-checking bench for multicycle_controlunit
module tb_multicycle_controlunit;
   import cu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] OpCode, Funct7;
   logic [2:0] Funct3;
   logic       imem_req, imem_ack, dmem_req, dmem_ack, br_taken;
   logic       IRWr, PCWr, RUWr, ALUASrc, ALUBSrc, DMWr, trap;
   logic [3:0] ALUOp;
   logic [2:0] ImmSrc, DMCtrl;
   logic [4:0] BrOp;
   logic [1:0] RUDataWrSrc;
   logic [1:0] retired;

   int n_checks = 0;
   int n_fail   = 0;

   int          lat, irwr_c, ruwr_c, ruwr_n, dreq_n, dmwr_n, asrc_n, bsrc_n;
   logic [31:0] pcwr_mask;
   logic [4:0]  brop_or;
   logic [3:0]  aluop_s;
   logic [2:0]  imm_s, dmctrl_s;
   logic [1:0]  rusrc_s;

   multicycle_controlunit #(.RET_W(2), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
      .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .br_taken(br_taken), .IRWr(IRWr), .PCWr(PCWr), .RUWr(RUWr), .ALUOp(ALUOp),
      .ImmSrc(ImmSrc), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .DMWr(DMWr), .DMCtrl(DMCtrl),
      .BrOp(BrOp), .RUDataWrSrc(RUDataWrSrc), .trap(trap), .retired(retired)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one instruction from its FETCH cycle (cycle 0) until the FSM requests the next fetch.
   // iw/dw = wait cycles before the memory acks; returns at the next instruction's cycle 0.
   task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input int iw, input int dw, input logic tk);
      int   iwc = 0, dwc = 0;
      logic fetched = 1'b0;
      logic done = 1'b0;
      lat = -1; irwr_c = -1; ruwr_c = -1; ruwr_n = 0; dreq_n = 0; dmwr_n = 0;
      asrc_n = 0; bsrc_n = 0; pcwr_mask = '0; brop_or = '0;
      OpCode = op; Funct3 = f3; Funct7 = f7; br_taken = tk;
      for (int c = 0; c < 32 && !done; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         if (c > 0 && fetched && imem_req) begin
            lat  = c;
            done = 1'b1;
         end else begin
            imem_ack = imem_req && !fetched && (iwc == iw);
            dmem_ack = dmem_req && (dwc == dw);
            @(negedge clk);
            if (IRWr && irwr_c < 0) irwr_c = c;
            if (RUWr) begin ruwr_n++; ruwr_c = c; end
            if (PCWr) pcwr_mask[c[4:0]] = 1'b1;
            if (dmem_req) dreq_n++;
            if (DMWr) dmwr_n++;
            if (ALUASrc) asrc_n++;
            if (ALUBSrc) bsrc_n++;
            brop_or  = brop_or | BrOp;
            aluop_s  = ALUOp;
            imm_s    = ImmSrc;
            rusrc_s  = RUDataWrSrc;
            dmctrl_s = DMCtrl;
            if (imem_req && !imem_ack) iwc++;
            if (imem_ack) fetched = 1'b1;
            if (dmem_req && !dmem_ack) dwc++;
         end
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      check({tag, "_completes"}, 32'(done), 32'd1);
   endtask

   // Fetches an illegal instruction; expects TRAP after DECODE with acks ignored and no strobes.
   task automatic run_trap(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7);
      int         strobes = 0;
      logic [1:0] r0 = retired;
      OpCode = op; Funct3 = f3; Funct7 = f7; imem_ack = 1'b1;
      @(negedge clk);
      check({tag, "_irwr"}, 32'(IRWr), 32'd1);
      @(posedge clk); #1; imem_ack = 1'b0;
      @(negedge clk);
      check({tag, "_trap_in_decode"}, 32'(trap), 32'd0);
      @(posedge clk); #1; imem_ack = 1'b1; dmem_ack = 1'b1;
      @(negedge clk);
      check({tag, "_trap_after_decode"}, 32'(trap), 32'd1);
      repeat (4) begin
         strobes += int'(IRWr) + int'(PCWr) + int'(RUWr) + int'(imem_req) + int'(dmem_req) + int'(DMWr);
         @(posedge clk); #1;
         @(negedge clk);
      end
      check({tag, "_strobes"}, 32'(strobes), 32'd0);
      check({tag, "_sticky"}, 32'(trap), 32'd1);
      check({tag, "_retired"}, 32'(retired), 32'(r0));
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask

   // Called at a negedge: async reset, checks, release just after the following posedge.
   task automatic reset_pulse(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_trap"}, 32'(trap), 32'd0);
      check({tag, "_retired"}, 32'(retired), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check({tag, "_fetch"}, 32'(imem_req), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; OpCode = '0; Funct3 = '0; Funct7 = '0;
      imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_irwr", 32'(IRWr), 32'd0);
      check("rst_pcwr", 32'(PCWr), 32'd0);
      check("rst_ruwr", 32'(RUWr), 32'd0);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_dmwr", 32'(DMWr), 32'd0);
      check("rst_trap", 32'(trap), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      check("rst_aluop", 32'(ALUOp), 32'd0);
      check("rst_rusrc", 32'(RUDataWrSrc), 32'd0);
      rst_n = 1'b1;

      run("add", OP_R, 3'b000, 7'b0000000, 0, 0, 1'b0);
      check("add_irwr_c", irwr_c, 0);
      check("add_ruwr_c", ruwr_c, 3);
      check("add_pcwr", pcwr_mask, 32'h8);
      check("add_aluop", 32'(aluop_s), 32'd0);
      check("add_bsrc", bsrc_n, 0);
      check("add_lat", lat, 4);
      check("add_retired", 32'(retired), 32'd1);

      run("lw", OP_LOAD, 3'b010, 7'b0000000, 0, 3, 1'b0);
      check("lw_dreq_n", dreq_n, 4);
      check("lw_dmwr_n", dmwr_n, 0);
      check("lw_rusrc", 32'(rusrc_s), 32'd1);
      check("lw_ruwr_c", ruwr_c, 7);
      check("lw_pcwr", pcwr_mask, 32'h80);
      check("lw_dmctrl", 32'(dmctrl_s), 32'd2);
      check("lw_bsrc", bsrc_n, 1);
      check("lw_lat", lat, 8);
      check("lw_retired", 32'(retired), 32'd2);

      run("beq_t", OP_BR, 3'b000, 7'b0000000, 0, 0, 1'b1);
      check("beq_t_lat", lat, 3);
      check("beq_t_pcwr", pcwr_mask, 32'h4);
      check("beq_t_ruwr_n", ruwr_n, 0);
      check("beq_t_brop", 32'(brop_or), 32'h10);
      check("beq_t_retired", 32'(retired), 32'd3);

      run("beq_nt", OP_BR, 3'b000, 7'b0000000, 0, 0, 1'b0);
      check("beq_nt_lat", lat, 3);
      check("beq_nt_pcwr", pcwr_mask, 32'h0);
      check("beq_nt_ruwr_n", ruwr_n, 0);
      check("beq_nt_retired_wrap", 32'(retired), 32'd0);

      run("sw", OP_STORE, 3'b010, 7'b0000000, 0, 0, 1'b0);
      check("sw_lat", lat, 4);
      check("sw_dmwr_n", dmwr_n, 1);
      check("sw_pcwr", pcwr_mask, 32'h8);
      check("sw_ruwr_n", ruwr_n, 0);
      check("sw_imm", 32'(imm_s), 32'(IMM_S));
      check("sw_retired", 32'(retired), 32'd1);

      run("sub", OP_R, 3'b000, 7'b0100000, 0, 0, 1'b0);
      check("sub_aluop", 32'(aluop_s), 32'h8);

      run("addi", OP_I, 3'b000, 7'b0100000, 0, 0, 1'b0);
      check("addi_aluop", 32'(aluop_s), 32'h0);

      run("srai", OP_I, 3'b101, 7'b0100000, 0, 0, 1'b0);
      check("srai_aluop", 32'(aluop_s), 32'hd);
      check("srai_retired", 32'(retired), 32'd0);

      run("lui", OP_LUI, 3'b000, 7'b0000000, 0, 0, 1'b0);
      check("lui_aluop", 32'(aluop_s), 32'h7);
      check("lui_imm", 32'(imm_s), 32'(IMM_U));
      check("lui_lat", lat, 4);

      run("jal", OP_JAL, 3'b000, 7'b0000000, 0, 0, 1'b0);
      check("jal_pcwr", pcwr_mask, 32'h4);
      check("jal_ruwr_c", ruwr_c, 3);
      check("jal_rusrc", 32'(rusrc_s), 32'd2);
      check("jal_brop", 32'(brop_or), 32'h08);
      check("jal_asrc", asrc_n, 1);
      check("jal_lat", lat, 4);

      run("add_iw3", OP_R, 3'b000, 7'b0000000, 3, 0, 1'b0);
      check("add_iw3_irwr_c", irwr_c, 3);
      check("add_iw3_lat", lat, 7);
      check("add_iw3_trap", 32'(trap), 32'd0);
      check("add_iw3_retired", 32'(retired), 32'd3);

      run_trap("illegal", 7'b1111111, 3'b000, 7'b0000000);
      reset_pulse("illegal_rst");

      // Store interrupted by reset while its MEM request is outstanding.
      OpCode = OP_STORE; Funct3 = 3'b010; Funct7 = '0; imem_ack = 1'b1;
      @(negedge clk);
      @(posedge clk); #1; imem_ack = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      check("sw_rst_dmem_req_before", 32'(dmem_req), 32'd1);
      check("sw_rst_dmwr_before", 32'(DMWr), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("sw_rst_dmem_req_async", 32'(dmem_req), 32'd0);
      check("sw_rst_dmwr_async", 32'(DMWr), 32'd0);
      check("sw_rst_retired", 32'(retired), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_trap("muldiv_off", OP_R, 3'b000, F7_MULDIV);
      reset_pulse("muldiv_rst");

      // Fetch never acknowledged: 4 unacked request cycles then TRAP.
      imem_ack = 1'b0;
      repeat (3) begin @(negedge clk); @(posedge clk); #1; end
      @(negedge clk);
      check("tmo_trap_c3", 32'(trap), 32'd0);
      check("tmo_req_c3", 32'(imem_req), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("tmo_trap_c4", 32'(trap), 32'd1);
      check("tmo_req_c4", 32'(imem_req), 32'd0);
      reset_pulse("tmo_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
